// File: rtl/up_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module : up_counter_pkg
// Brief  : Shared defaults and the count_t type for the up_counter slice.
// Rev    : 1.0  initial release
// ============================================================================
package up_counter_pkg;

  localparam int c_def_width   = 4;
  localparam int c_def_max_val = 15;

  typedef logic [c_def_width-1:0] count_t;

endpackage : up_counter_pkg
`default_nettype wire

// File: rtl/up_counter_tff.sv
`default_nettype none
// ============================================================================
// Module : tff_sync
// Brief  : Synchronous-reset toggle flip-flop with a parallel-load override.
// Rev    : 1.0  initial release
// ============================================================================
module tff_sync
  import up_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic ld_d,
  output logic q,
  output logic qbar
);

  logic r_q;

  // Load beats toggle so the parent can force any value (wrap, clamp, load).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (ld) begin
      r_q <= ld_d;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule : tff_sync
`default_nettype wire

// File: rtl/up_counter.sv
`default_nettype none
// ============================================================================
// Module : up_counter
// Brief  : Loadable synchronous up counter built from toggle flip-flops.
//          Define UP_COUNTER_SAT_EN to saturate at MAX_VAL instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module up_counter
  import up_counter_pkg::*;
#(
  parameter int WIDTH   = c_def_width,
  parameter int MAX_VAL = c_def_max_val
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] countbar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_term_val;
  logic [WIDTH-1:0] w_ld_d;
  logic             w_tc;
  logic             w_term_step;
  logic             w_ld;
  logic             w_wrap_next;
  logic             r_wrap;

  assign w_tc           = (w_q == c_max);
  assign w_load_clamped = (load_val > c_max) ? c_max : load_val;

  // Counting past MAX_VAL is handled as a forced load, since MAX_VAL need not
  // be the natural 2^WIDTH-1 rollover point of the toggle chain.
  assign w_term_step = en & ~load & w_tc;

`ifdef UP_COUNTER_SAT_EN
  assign w_term_val  = c_max;
  assign w_wrap_next = 1'b0;
`else
  assign w_term_val  = '0;
  assign w_wrap_next = w_term_step;
`endif

  assign w_ld   = load | w_term_step;
  assign w_ld_d = load ? w_load_clamped : w_term_val;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign w_carry[gi] = en;
      end else begin : g_upper
        assign w_carry[gi] = w_carry[gi-1] & w_q[gi-1];
      end

      tff_sync u_tff (
        .clk  (clk),
        .rst  (rst),
        .t    (w_carry[gi]),
        .ld   (w_ld),
        .ld_d (w_ld_d[gi]),
        .q    (w_q[gi]),
        .qbar (w_qbar[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
    end
  end

  assign count    = w_q;
  assign countbar = w_qbar;
  assign tc       = w_tc;
  assign wrap     = r_wrap;

endmodule : up_counter
`default_nettype wire
